// File: rtl/iir_pkg.sv
// Shared constants and helpers for the IIR filter chain (input, zero and pole sections).
package iir_pkg;

  localparam int IIR_DW = 10;
  localparam int IIR_OW = 12;

  // Offset-binary to two's complement: flipping the MSB recentres the code on zero.
  function automatic logic signed [IIR_DW-1:0] ob2tc(input logic [IIR_DW-1:0] ob);
    return {~ob[IIR_DW-1], ob[IIR_DW-2:0]};
  endfunction

endpackage

// File: rtl/iir_rate_gen.sv
// Decimation rate counter: counts 0..DIV-1 while enabled, clears when en drops,
// and decodes the last cycle of a period and the accumulate window.
module iir_rate_gen #(
  parameter int DIV = 50,
  parameter int CW  = $clog2(DIV)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last,
  output logic          win
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    last = (cnt_q == CW'(DIV - 1));
    // Registered samples of the four window inputs sit here in cnt=DIV-4..DIV-2;
    // the fourth is folded in directly on the last cycle.
    win  = (cnt_q >= CW'(DIV - 4)) && (cnt_q <= CW'(DIV - 2));
    cnt_d = cnt_q + CW'(1);
    if (!en || last) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/iir_sample_in.sv
// IIR front end: registers the offset-binary ADC word, converts to two's complement
// and decimates by DIV. Define IIR_IN_AVG_EN for 4-sample boxcar decimation.
module iir_sample_in
  import iir_pkg::*;
#(
  parameter int DW  = IIR_DW,
  parameter int OW  = IIR_OW,
  parameter int DIV = 50
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 en,
  input  logic [DW-1:0]        data_in,
  output logic signed [OW-1:0] dout,
  output logic                 out_valid
);

  localparam int CW = $clog2(DIV);

  if (DIV < 5 || DIV > 65535 || OW != DW + 2 || DW != IIR_DW) begin : g_bad_cfg
    $error("iir_sample_in: DIV must be 5..65535, DW must be IIR_DW and OW must be DW+2");
  end

  logic [DW-1:0]        d1_q, d1_d;
  logic signed [OW-1:0] dout_q, dout_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [DW-1:0] smp;
  logic signed [OW-1:0] smp_ext;
  logic signed [OW-1:0] result;
  logic [CW-1:0]        cnt;
  logic                 last;
  logic                 win;

  iir_rate_gen #(
    .DIV (DIV),
    .CW  (CW)
  ) u_rate (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (en),
    .cnt     (cnt),
    .last    (last),
    .win     (win)
  );

  always_comb begin
    d1_d    = data_in;
    smp     = ob2tc(d1_q);
    smp_ext = {{(OW-DW){smp[DW-1]}}, smp};
  end

`ifdef IIR_IN_AVG_EN
  logic signed [OW-1:0] acc_q, acc_d;
  logic [CW-1:0]        unused_cnt;

  assign unused_cnt = cnt;

  // Four DW-bit samples sum to at most 4x full scale, which OW=DW+2 holds exactly.
  always_comb begin
    result = acc_q + smp_ext;
    acc_d  = acc_q;
    if (!en || last) begin
      acc_d = '0;
    end else if (win) begin
      acc_d = acc_q + smp_ext;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  logic unused_rate;

  assign unused_rate = ^{cnt, win};

  always_comb begin
    result = {smp, 2'b00};
  end
`endif

  // Output stage: load on the final enabled cycle of a period, strobe for one cycle.
  always_comb begin
    dout_d      = dout_q;
    out_valid_d = 1'b0;
    if (en && last) begin
      dout_d      = result;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      d1_q        <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      d1_q        <= d1_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_iir_sample_in.sv
// Directed bench for iir_sample_in: two instances (DIV=50 and DIV=8) on shared inputs.
module tb_iir_sample_in;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        en;
  logic [9:0]  data_in;
  logic [11:0] dout50, dout8;
  logic        vld50, vld8;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  iir_sample_in #(.DW(10), .OW(12), .DIV(50)) u_dut50 (
    .sys_clk   (clk),
    .sys_rst   (sys_rst),
    .en        (en),
    .data_in   (data_in),
    .dout      (dout50),
    .out_valid (vld50)
  );

  iir_sample_in #(.DW(10), .OW(12), .DIV(8)) u_dut8 (
    .sys_clk   (clk),
    .sys_rst   (sys_rst),
    .en        (en),
    .data_in   (data_in),
    .dout      (dout8),
    .out_valid (vld8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first released cycle, which is cnt=0 when en=1.
  task automatic start_period();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    en      = 1'b1;
    data_in = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({dout50, vld50, dout8, vld8} !== 26'd0) begin
        errors++;
        $display("FAIL reset cycle %0d: dout50=%h vld50=%b dout8=%h vld8=%b, required all zero",
                 i, dout50, vld50, dout8, vld8);
      end
    end
    sys_rst = 1'b0;
    checks++;
    if ({dout50, vld50, dout8, vld8} !== 26'd0) begin
      errors++;
      $display("FAIL reset release: dout50=%h vld50=%b dout8=%h vld8=%b, required all zero",
               dout50, vld50, dout8, vld8);
    end
  endtask

  task automatic test_const50();
    logic [11:0] exp_d;
    en = 1'b1;
    data_in = 10'h3FF;
    start_period();
    for (int k = 0; k <= 150; k++) begin
      data_in = (k < 50) ? 10'h3FF : (k < 100) ? 10'h200 : 10'h000;
      exp_d   = (k < 50) ? 12'h000 : (k < 100) ? 12'h7FC : (k < 150) ? 12'h000 : 12'h800;
      checks++;
      if (vld50 !== (k == 50 || k == 100 || k == 150)) begin
        errors++;
        $display("FAIL const50 valid k=%0d: got %b", k, vld50);
      end
      checks++;
      if (dout50 !== exp_d) begin
        errors++;
        $display("FAIL const50 dout k=%0d: got %h required %h", k, dout50, exp_d);
      end
      tick();
    end
  endtask

  task automatic test_window8();
    logic [11:0] exp_d;
    int c;
`ifdef IIR_IN_AVG_EN
    exp_d = 12'd10;
`else
    exp_d = 12'd20;
`endif
    en = 1'b1;
    data_in = 10'h3FF;
    start_period();
    for (int k = 0; k <= 16; k++) begin
      c = k % 8;
`ifdef IIR_IN_AVG_EN
      data_in = (c >= 3 && c <= 6) ? 10'h201 + 10'(c - 3) : 10'h3FF;
`else
      data_in = (c == 6) ? 10'h205 : 10'h3FF;
`endif
      checks++;
      if (vld8 !== (k == 8 || k == 16)) begin
        errors++;
        $display("FAIL window8 valid k=%0d: got %b", k, vld8);
      end
      checks++;
      if (dout8 !== ((k < 8) ? 12'h000 : exp_d)) begin
        errors++;
        $display("FAIL window8 dout k=%0d: got %h required %h", k, dout8,
                 (k < 8) ? 12'h000 : exp_d);
      end
      tick();
    end
  endtask

  task automatic test_en_drop();
    en = 1'b1;
    data_in = 10'h3FF;
    start_period();
    for (int k = 0; k < 70; k++) begin
      data_in = (k < 50) ? 10'h3FF : 10'h000;
      checks++;
      if (vld50 !== (k == 50) || dout50 !== ((k < 50) ? 12'h000 : 12'h7FC)) begin
        errors++;
        $display("FAIL en_drop lead k=%0d: vld=%b dout=%h", k, vld50, dout50);
      end
      tick();
    end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (vld50 !== 1'b0 || dout50 !== 12'h7FC) begin
        errors++;
        $display("FAIL en_drop idle %0d: vld=%b dout=%h required 0/7fc", k, vld50, dout50);
      end
      tick();
    end
    en = 1'b1;
    for (int j = 0; j <= 50; j++) begin
      checks++;
      if (vld50 !== (j == 50) || dout50 !== ((j < 50) ? 12'h7FC : 12'h800)) begin
        errors++;
        $display("FAIL en_drop resume j=%0d: vld=%b dout=%h", j, vld50, dout50);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    data_in = 10'h3FF;
    start_period();
    for (int k = 0; k < 15; k++) begin
      data_in = (k < 8) ? 10'h3FF : 10'h000;
      checks++;
      if (vld8 !== (k == 8) || dout8 !== ((k < 8) ? 12'h000 : 12'h7FC)) begin
        errors++;
        $display("FAIL reset_mid lead k=%0d: vld=%b dout=%h", k, vld8, dout8);
      end
      tick();
    end
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      checks++;
      if (vld8 !== (j == 8) || dout8 !== ((j < 8) ? 12'h000 : 12'h800)) begin
        errors++;
        $display("FAIL reset_mid restart j=%0d: vld=%b dout=%h", j, vld8, dout8);
      end
      tick();
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    en      = 1'b0;
    data_in = '0;
    test_reset();
    test_const50();
    test_window8();
    test_en_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
